matrix_multiplier: RTL and testbench
====================================

Name: matrix_multiplier

Overview:
- Sequential integer matrix multiplier: C[M][N] = A[M][K] x B[K][N], unsigned 8-bit operands.
- Uses an MxN array of multiply-accumulate cells. Each cell consumes one k index per clock.
- Sits beside the NPU control logic as a fixed-size GEMM tile engine with a start/done handshake.

Parameters:
- M, 4, rows of A and C.
- K, 32, inner dimension (columns of A, rows of B).
- N, 4, columns of B and C.
- DW, 8, operand width (unsigned).
- OW, 16, result width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a computation; sampled on rising edge.
- a  input  [DW-1:0] unpacked [0:M-1][0:K-1]  matrix A.
- b  input  [DW-1:0] unpacked [0:K-1][0:N-1]  matrix B.
- c  output  [OW-1:0] unpacked [0:M-1][0:N-1]  result matrix, registered.
- done  output  1  result valid, level.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, k counter=0, all c=0, done=0. A reset mid-computation aborts it; no partial result is retained.
- States: IDLE, COMPUTE, DONE.
- IDLE/DONE with start=1 at edge E:
  - all accumulators cleared to 0, k=0, done=0, state goes to COMPUTE.
- COMPUTE, each edge:
  - every cell (i,j) does acc[i][j] += a[i][k]*b[k][j]; then k increments.
  - Edges E+1..E+K cover k=0..K-1.
  - At edge E+K, after the last accumulate, state goes to DONE and done=1.
- Latency: done rises exactly K (32) clocks after the start-sampling edge. c holds the final values when done rises.
- DONE: done stays high and c stays stable until the next accepted start or reset.
- start while in COMPUTE is ignored; no restart and no queuing.
- start held high across multiple cycles: only the IDLE/DONE edge triggers. A start still high at the end of DONE entry is not re-accepted until it has been seen low. Implement this with a registered previous-start (edge detect).
- Operands are not captured. a and b must stay stable from the start edge until done; they are read combinationally indexed by k.
- Arithmetic:
  - Product is 2*DW bits unsigned.
  - Accumulate is modulo 2^OW: wrap, no saturation, unless SATURATE_EN is defined.
- c is driven directly from the accumulator registers. Intermediate values are visible while done=0 and are not guaranteed meaningful.

Optional Feature:
- Macro: MATMUL_SATURATE_EN.
- Defined:
  - accumulators widen internally to 2*DW+$clog2(K) bits (21 bits).
  - c = min(acc, 2^OW-1), i.e. saturates at 16'hFFFF.
- Undefined:
  - OW-bit wrapping accumulators.
  - No extra storage.

Decomposition:
- Package matmul_pkg:
  - default M/K/N/DW/OW localparams;
  - state enum type (IDLE, COMPUTE, DONE);
  - accumulator-width localparam derived from the macro.
- Sub-module mac_cell, instantiated MxN times via generate:
  - inputs clk, rst_n, clr, en, x[DW], y[DW];
  - output acc (wrap or saturating view).
- The top level holds the FSM, the k counter and operand-select muxes.

Test Plan:
- a[i][k]=k+1, b[k][j]=k+1, 1-cycle start pulse -> done after 32 clocks; every c[i][j]=11440 (sum of squares 1..32).
- All a=1, b=1 -> every c=32. Check done=0 throughout COMPUTE and that done rose exactly 32 cycles after start.
- All a=255, b=255:
  - without macro -> every c=49184 (2080800 mod 65536);
  - with MATMUL_SATURATE_EN -> every c=65535.
- Mixed case: a[0][k]=1 only for k=0 (others 0) and b[0][j]=j+2 -> c[0][j]=j+2; c rows 1..3 = 0.
- Pulse start again at cycle 10 of COMPUTE -> ignored; done still at 32 and results unchanged. Then a start in DONE with new operands -> done drops next cycle and the new result appears 32 cycles later.
- Assert rst_n=0 at cycle 15 of COMPUTE -> c=0 and done=0 immediately (asynchronous). After release, no done until a new start.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared defaults, FSM state type and accumulator width for the GEMM tile engine.
// Build option: MATMUL_SATURATE_EN widens the accumulators and saturates the result view.
package matmul_pkg;

    localparam int DEF_M  = 4;
    localparam int DEF_K  = 32;
    localparam int DEF_N  = 4;
    localparam int DEF_DW = 8;
    localparam int DEF_OW = 16;

`ifdef MATMUL_SATURATE_EN
    localparam int ACC_W = 2*DEF_DW + $clog2(DEF_K);
`else
    localparam int ACC_W = DEF_OW;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mm_state_e;

endpackage

// File: rtl/mac_cell.sv
// One multiply-accumulate cell: acc += x*y when en, cleared by clr.
// Build option: MATMUL_SATURATE_EN gives a wide accumulator with a clamped OW-bit view.
module mac_cell
    import matmul_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int OW = DEF_OW,
    parameter int AW = ACC_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic [OW-1:0] acc
);

    logic [2*DW-1:0] prod;
    logic [AW-1:0]   acc_q;

    assign prod = x * y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + AW'(prod);
        end
    end

`ifdef MATMUL_SATURATE_EN
    // Any set bit above OW means the true sum exceeds the output range.
    assign acc = (|acc_q[AW-1:OW]) ? '1 : acc_q[OW-1:0];
`else
    assign acc = acc_q;
`endif

endmodule

// File: rtl/matrix_multiplier.sv
// Fixed-size GEMM tile engine: C = A x B over K clocks with a start/done handshake.
// Build option: MATMUL_SATURATE_EN (saturating results, see mac_cell).
//
// state   | meaning
// IDLE    | waiting for a start rising edge, c holds reset value
// COMPUTE | one k index accumulated per clock, k = 0..K-1
// DONE    | result valid on c, done high until next start or reset
module matrix_multiplier
    import matmul_pkg::*;
#(
    parameter int M  = DEF_M,
    parameter int K  = DEF_K,
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int OW = DEF_OW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a [0:M-1][0:K-1],
    input  logic [DW-1:0] b [0:K-1][0:N-1],
    output logic [OW-1:0] c [0:M-1][0:N-1],
    output logic          done
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    mm_state_e     state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          start_q;
    logic          start_rise;
    logic          clr;
    logic          en;

    // Edge detect so a start held high across DONE entry does not relaunch.
    assign start_rise = start && !start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            start_q <= start;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        clr     = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    clr     = 1'b1;
                    k_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                en = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done = (state_q == DONE);

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mac_cell #(
                .DW (DW),
                .OW (OW),
                .AW (ACC_W)
            ) u_mac (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .en    (en),
                .x     (a[gi][k_q]),
                .y     (b[k_q][gj]),
                .acc   (c[gi][gj])
            );
        end
    end

endmodule

// File: tb/tb_matrix_multiplier.sv
// Directed self-checking bench for matrix_multiplier with hand-computed results.
// Expected saturation values follow MATMUL_SATURATE_EN when it is defined.
module tb_matrix_multiplier;

    localparam int M  = 4;
    localparam int K  = 32;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 16;

`ifdef MATMUL_SATURATE_EN
    localparam int EXP_255 = 65535;
`else
    localparam int EXP_255 = 49184;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] a [0:M-1][0:K-1];
    logic [DW-1:0] b [0:K-1][0:N-1];
    logic [OW-1:0] c [0:M-1][0:N-1];
    logic          done;

    int n_chk  = 0;
    int n_pass = 0;

    matrix_multiplier #(.M(M), .K(K), .N(N), .DW(DW), .OW(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_all_c(input string tag, input int val);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s c[%0d][%0d]", tag, i, j), 32'(c[i][j]), 32'(val));
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++)
                a[i][k] = (mode == 0) ? DW'(k + 1) : (mode == 1) ? 8'd1 :
                          (mode == 2) ? 8'd255 : ((i == 0 && k == 0) ? 8'd1 : 8'd0);
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++)
                b[k][j] = (mode == 0) ? DW'(k + 1) : (mode == 1) ? 8'd1 :
                          (mode == 2) ? 8'd255 : ((k == 0) ? DW'(j + 2) : 8'd0);
    endtask

    task automatic launch(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = hold;
        chk("done low after start edge", 32'(done), 32'd0);
    endtask

    // Counts negedges after the start edge until done; poke re-pulses start mid-run.
    task automatic run_to_done(input int poke, input bit hold, output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = hold || (cyc == poke);
            if (done) break;
        end
    endtask

    int  cyc;
    bit  seen;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill(1);
        #22;
        chk("reset done", 32'(done), 32'd0);
        chk_all_c("reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle done", 32'(done), 32'd0);

        // Squares sum, with an ignored start pulse at cycle 10 of COMPUTE.
        fill(0);
        launch(1'b0);
        run_to_done(10, 1'b0, cyc);
        chk("latency squares", 32'(cyc), 32'(K));
        chk_all_c("squares", 11440);
        repeat (3) @(negedge clk);
        chk("done holds", 32'(done), 32'd1);
        chk("c stable", 32'(c[3][3]), 32'd11440);

        // Restart from DONE with new operands.
        fill(1);
        launch(1'b0);
        run_to_done(-1, 1'b0, cyc);
        chk("latency ones", 32'(cyc), 32'(K));
        chk_all_c("ones", 32);

        // Start held high through the whole run must not relaunch from DONE.
        fill(2);
        launch(1'b1);
        run_to_done(-1, 1'b1, cyc);
        chk("latency 255", 32'(cyc), 32'(K));
        chk_all_c("max", EXP_255);
        repeat (5) @(negedge clk);
        chk("held start no relaunch", 32'(done), 32'd1);
        start = 1'b0;

        // Single nonzero k term.
        fill(3);
        launch(1'b0);
        run_to_done(-1, 1'b0, cyc);
        chk("latency mixed", 32'(cyc), 32'(K));
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("mixed c[%0d][%0d]", i, j), 32'(c[i][j]),
                    (i == 0) ? 32'(j + 2) : 32'd0);

        // Asynchronous abort mid-computation.
        fill(1);
        launch(1'b0);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort done", 32'(done), 32'd0);
        chk_all_c("abort", 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= done;
        end
        chk("no done after reset", 32'(seen), 32'd0);
        chk("c cleared after reset", 32'(c[2][1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
